// File: rtl/mem_access_controller.sv
// mem_access_controller: CPU-side initiator for the byte-wide RAM
// Enable/MOV/RW/MOC handshake. Splits byte/half/word requests into
// sequential single-byte transfers, assembles loads big-endian with
// sign/zero extension and reports Done/Error.
module mem_access_controller #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              ReqRW,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [31:0]       RData,
  output logic              Enable,
  output logic              MOV,
  output logic              RW,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        DataOut,
  input  logic [7:0]        DataIn,
  input  logic              MOC
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT_MOC, S_RELEASE, S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic              r_rw, r_signed, r_moc, r_err, r_busy, r_done, r_error;
  logic [1:0]        r_size, r_k, r_last;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata, r_shift, r_rdata;
  logic [TW-1:0]     r_tmo;

  logic              w_legal, w_moc_rise, w_tmo_hit;
  logic [1:0]        w_last, w_idx;
  logic [31:0]       w_load_ext;

  assign w_moc_rise = MOC & ~r_moc;
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));

  // Legality and byte count of the request presented at the inputs
  always_comb begin
    w_legal = 1'b0;
    w_last  = 2'd0;
    case (ReqSize)
      2'b00: begin w_legal = 1'b1;                   w_last = 2'd0; end
      2'b01: begin w_legal = ~ReqAddr[0];            w_last = 2'd1; end
      2'b10: begin w_legal = (ReqAddr[1:0] == 2'b00); w_last = 2'd3; end
      default: begin w_legal = 1'b0;                 w_last = 2'd0; end
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; SETUP holds off MOV while the RAM still shows MOC
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (Req) w_next = w_legal ? S_SETUP : S_FINISH;
      S_SETUP:    if (!MOC) w_next = S_WAIT_MOC;
      S_WAIT_MOC: begin
        if (w_moc_rise)     w_next = S_RELEASE;
        else if (w_tmo_hit) w_next = S_FINISH;
      end
      S_RELEASE:  if (!MOC) w_next = (r_k == r_last) ? S_FINISH : S_SETUP;
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Request latch, byte/timeout counters, load shift register and status pulses
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rw     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_base   <= '0;
      r_wdata  <= '0;
      r_k      <= 2'd0;
      r_last   <= 2'd0;
      r_tmo    <= '0;
      r_moc    <= 1'b0;
      r_shift  <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_moc   <= MOC;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: if (Req) begin
          r_rw     <= ReqRW;
          r_size   <= ReqSize;
          r_signed <= ReqSigned;
          r_base   <= ReqAddr;
          r_wdata  <= ReqWData;
          r_last   <= w_last;
          r_k      <= 2'd0;
          r_tmo    <= '0;
          r_shift  <= '0;
          r_err    <= ~w_legal;
          r_busy   <= w_legal;
        end
        S_SETUP: r_tmo <= '0;
        S_WAIT_MOC: begin
          if (w_moc_rise) begin
            if (r_rw) r_shift <= {r_shift[23:0], DataIn};
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RELEASE: if (!MOC && (r_k != r_last)) r_k <= r_k + 1'b1;
        S_FINISH: begin
          r_done  <= 1'b1;
          r_error <= r_err;
          r_busy  <= 1'b0;
          if (r_rw && !r_err) r_rdata <= w_load_ext;
        end
        default: ;
      endcase
    end
  end

  // Store byte select (big-endian: byte k carries lane last-k) and load extension
  always_comb begin
    w_idx = r_last - r_k;
    case (w_idx)
      2'd0:    DataOut = r_wdata[7:0];
      2'd1:    DataOut = r_wdata[15:8];
      2'd2:    DataOut = r_wdata[23:16];
      default: DataOut = r_wdata[31:24];
    endcase
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & r_shift[7]}},  r_shift[7:0]};
      2'b01:   w_load_ext = {{16{r_signed & r_shift[15]}}, r_shift[15:0]};
      default: w_load_ext = r_shift;
    endcase
  end

  assign Enable  = (r_state == S_SETUP) || (r_state == S_WAIT_MOC) || (r_state == S_RELEASE);
  assign MOV     = (r_state == S_WAIT_MOC);
  assign RW      = r_rw;
  assign Address = r_base + ADDR_W'(r_k);
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Error   = r_error;
  assign RData   = r_rdata;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed testbench for mem_access_controller with a behavioural byte RAM.
module tb_mem_access_controller;

  logic        Clk = 1'b0;
  logic        Reset, Req, ReqRW, ReqSigned;
  logic [1:0]  ReqSize;
  logic [8:0]  ReqAddr, Address;
  logic [31:0] ReqWData, RData;
  logic        Busy, Done, Error, Enable, MOV, RW, MOC;
  logic [7:0]  DataOut, DataIn;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:511];
  int  hold_cycles = 1;
  bit  stuck = 1'b0;
  int  hold_cnt = 0;
  int  mov_cycles = 0;
  int  viol = 0;

  // Results of the last do_req
  int          lat, movd;
  logic        done_s, err_s, busy_acc, busy_s;
  logic [31:0] rdat_s;

  mem_access_controller #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqRW(ReqRW), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .Busy(Busy), .Done(Done), .Error(Error), .RData(RData),
    .Enable(Enable), .MOV(MOV), .RW(RW), .Address(Address),
    .DataOut(DataOut), .DataIn(DataIn), .MOC(MOC)
  );

  initial forever #5 Clk = ~Clk;

  // RAM responder: raise MOC on the negedge after seeing MOV, hold it
  // hold_cycles cycles, then drop once MOV is gone.
  initial begin
    MOC = 1'b0;
    DataIn = 8'h00;
    forever begin
      @(negedge Clk);
      if (!MOC) begin
        if (MOV && Enable && !stuck) begin
          if (RW) DataIn = mem[Address];
          else    mem[Address] = DataOut;
          MOC = 1'b1;
          hold_cnt = hold_cycles;
        end
      end else begin
        hold_cnt = hold_cnt - 1;
        if (hold_cnt <= 0 && !MOV) MOC = 1'b0;
      end
    end
  end

  // Handshake monitor: MOV must not rise with MOC high; bus stable while MOV
  initial begin
    logic       pm, pr;
    logic [8:0] pa;
    logic [7:0] pd;
    pm = 1'b0; pr = 1'b0; pa = '0; pd = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (MOV) begin
        mov_cycles = mov_cycles + 1;
        if (!pm && MOC) viol = viol + 1;
        if (pm && (Address !== pa || RW !== pr || DataOut !== pd)) viol = viol + 1;
      end
      pm = MOV; pa = Address; pr = RW; pd = DataOut;
    end
  end

  // Issue one request and wait (bounded) for Done
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic sgn,
                        input logic [8:0] a, input logic [31:0] wd, input bit extra);
    int m0;
    @(negedge Clk);
    ReqRW = rw; ReqSize = sz; ReqSigned = sgn; ReqAddr = a; ReqWData = wd;
    Req = 1'b1;
    m0 = mov_cycles;
    @(posedge Clk);
    #1;
    Req = 1'b0;
    busy_acc = Busy;
    lat = 0;
    while (Done !== 1'b1 && lat < 200) begin
      @(posedge Clk);
      #1;
      lat = lat + 1;
      if (extra) begin
        if (lat == 3) begin
          Req = 1'b1; ReqAddr = 9'h100; ReqRW = 1'b0; ReqSize = 2'b00; ReqWData = 32'h55;
        end
        if (lat == 5) Req = 1'b0;
      end
    end
    done_s = Done; err_s = Error; rdat_s = RData; busy_s = Busy;
    movd = mov_cycles - m0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; ReqRW = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0;
    for (int unsigned i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Busy, Done, Error, Enable, MOV, RW} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {Busy, Done, Error, Enable, MOV, RW});
    end
    checks++;
    if ({Address, DataOut, RData} !== 49'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h/%h expected 0/0/0", Address, DataOut, RData);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
    checks++;
    if (lat != 13 || err_s !== 1'b0 || busy_acc !== 1'b1 || busy_s !== 1'b0) begin
      errors++; $display("FAIL word_store: lat=%0d err=%b busyacc=%b busy=%b expected 13 0 1 0", lat, err_s, busy_acc, busy_s);
    end
    checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_mem: got %h expected deadbeef", {mem[16], mem[17], mem[18], mem[19]});
    end
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0);
    checks++;
    if (lat != 13 || err_s !== 1'b0 || rdat_s !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load: lat=%0d err=%b rdata=%h expected 13 0 deadbeef", lat, err_s, rdat_s);
    end
  endtask

  task automatic test_byte();
    mem[4] = 8'h33; mem[6] = 8'h33;
    do_req(1'b0, 2'b00, 1'b0, 9'h005, 32'h00000080, 1'b0);
    checks++;
    if (lat != 4 || {mem[4], mem[5], mem[6]} !== 24'h338033) begin
      errors++; $display("FAIL byte_store: lat=%0d mem=%h expected 4 338033", lat, {mem[4], mem[5], mem[6]});
    end
    do_req(1'b1, 2'b00, 1'b1, 9'h005, 32'h0, 1'b0);
    checks++;
    if (lat != 4 || rdat_s !== 32'hFFFFFF80) begin
      errors++; $display("FAIL byte_load_s: lat=%0d rdata=%h expected 4 ffffff80", lat, rdat_s);
    end
    do_req(1'b1, 2'b00, 1'b0, 9'h005, 32'h0, 1'b0);
    checks++;
    if (rdat_s !== 32'h00000080) begin
      errors++; $display("FAIL byte_load_u: got %h expected 00000080", rdat_s);
    end
  endtask

  task automatic test_half();
    do_req(1'b0, 2'b01, 1'b0, 9'h020, 32'h00008001, 1'b0);
    checks++;
    if (lat != 7 || {mem[32], mem[33]} !== 16'h8001) begin
      errors++; $display("FAIL half_store: lat=%0d mem=%h expected 7 8001", lat, {mem[32], mem[33]});
    end
    do_req(1'b1, 2'b01, 1'b0, 9'h020, 32'h0, 1'b0);
    checks++;
    if (rdat_s !== 32'h00008001) begin
      errors++; $display("FAIL half_load_u: got %h expected 00008001", rdat_s);
    end
    do_req(1'b1, 2'b01, 1'b1, 9'h020, 32'h0, 1'b0);
    checks++;
    if (lat != 7 || rdat_s !== 32'hFFFF8001) begin
      errors++; $display("FAIL half_load_s: lat=%0d rdata=%h expected 7 ffff8001", lat, rdat_s);
    end
    do_req(1'b1, 2'b01, 1'b1, 9'h021, 32'h0, 1'b0);
    checks++;
    if (lat != 1 || done_s !== 1'b1 || err_s !== 1'b1 || movd != 0 || rdat_s !== 32'hFFFF8001) begin
      errors++; $display("FAIL half_misalign: lat=%0d done=%b err=%b mov=%0d rdata=%h expected 1 1 1 0 ffff8001",
                         lat, done_s, err_s, movd, rdat_s);
    end
    do_req(1'b1, 2'b11, 1'b0, 9'h030, 32'h0, 1'b0);
    checks++;
    if (lat != 1 || err_s !== 1'b1 || movd != 0) begin
      errors++; $display("FAIL size_illegal: lat=%0d err=%b mov=%0d expected 1 1 0", lat, err_s, movd);
    end
    mem[34] = 8'h5A;
    do_req(1'b0, 2'b10, 1'b0, 9'h022, 32'h12345678, 1'b0);
    checks++;
    if (lat != 1 || err_s !== 1'b1 || movd != 0 || mem[34] !== 8'h5A) begin
      errors++; $display("FAIL word_misalign: lat=%0d err=%b mov=%0d mem=%h expected 1 1 0 5a", lat, err_s, movd, mem[34]);
    end
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    do_req(1'b1, 2'b10, 1'b0, 9'h040, 32'h0, 1'b0);
    checks++;
    if (lat != 18 || err_s !== 1'b1 || movd != 16 || busy_s !== 1'b0 || rdat_s !== 32'hFFFF8001) begin
      errors++; $display("FAIL timeout: lat=%0d err=%b mov=%0d busy=%b rdata=%h expected 18 1 16 0 ffff8001",
                         lat, err_s, movd, busy_s, rdat_s);
    end
    stuck = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0);
    checks++;
    if (lat != 13 || err_s !== 1'b0 || rdat_s !== 32'hDEADBEEF) begin
      errors++; $display("FAIL after_timeout: lat=%0d err=%b rdata=%h expected 13 0 deadbeef", lat, err_s, rdat_s);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int unsigned i = 96; i < 100; i++) mem[i] = 8'hAA;
    @(negedge Clk);
    ReqRW = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0; ReqAddr = 9'h060; ReqWData = 32'h11223344;
    Req = 1'b1;
    @(posedge Clk);
    #1;
    Req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (MOV === 1'b1 && Address === 9'h062) found = 1'b1;
      else begin @(posedge Clk); #1; end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL reset_mid_reach: byte2 seen=%b expected 1", found);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({MOV, Enable, Busy} !== 3'b000 || Address !== 9'h000 || RData !== 32'h0) begin
      errors++; $display("FAIL reset_mid_outs: mov/en/busy=%b addr=%h rdata=%h expected 000 000 0",
                         {MOV, Enable, Busy}, Address, RData);
    end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({mem[96], mem[97], mem[98], mem[99]} !== 32'h1122AAAA || Enable !== 1'b0) begin
      errors++; $display("FAIL reset_mid_mem: got %h en=%b expected 1122aaaa 0", {mem[96], mem[97], mem[98], mem[99]}, Enable);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem[256] = 8'h77;
    hold_cycles = 3;
    do_req(1'b0, 2'b10, 1'b0, 9'h080, 32'hCAFEF00D, 1'b1);
    checks++;
    if (lat != 21 || err_s !== 1'b0 || {mem[128], mem[129], mem[130], mem[131]} !== 32'hCAFEF00D) begin
      errors++; $display("FAIL hold_store: lat=%0d err=%b mem=%h expected 21 0 cafef00d",
                         lat, err_s, {mem[128], mem[129], mem[130], mem[131]});
    end
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Enable !== 1'b0 || mem[256] !== 8'h77) begin
      errors++; $display("FAIL extra_req: busy=%b en=%b mem100=%h expected 0 0 77", Busy, Enable, mem[256]);
    end
    hold_cycles = 1;
    do_req(1'b1, 2'b10, 1'b0, 9'h080, 32'h0, 1'b0);
    checks++;
    if (lat != 13 || rdat_s !== 32'hCAFEF00D) begin
      errors++; $display("FAIL hold_load: lat=%0d rdata=%h expected 13 cafef00d", lat, rdat_s);
    end
  endtask

  task automatic test_handshake();
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL handshake: violations=%0d expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- CPU-side initiator for the byte-wide RAM's Enable/MOV/RW/MOC handshake.
- Accepts one load/store request (byte, halfword or word) from the datapath and splits it into sequential single-byte RAM transfers.
- Waits for MOC on each byte, assembles read data big-endian with sign/zero extension, and reports completion or error.
- Sits between the MIPS datapath and the RAM.

Parameters:
- ADDR_W, 9: RAM byte-address width (512 bytes).
- TIMEOUT, 16: maximum clocks in WAIT_MOC before aborting with Error.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  request strobe; sampled only in IDLE.
- ReqRW  in  1  1 = read (load), 0 = write (store).
- ReqSize  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- ReqSigned  in  1  1 = sign-extend byte/half loads, 0 = zero-extend.
- ReqAddr  in  ADDR_W  start byte address.
- ReqWData  in  32  store data, right-justified.
- Busy  out  1  high from the accepting edge until Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse coincident with Done on misalignment, illegal size or timeout.
- RData  out  32  assembled, extended load data.
- Enable  out  1  RAM enable.
- MOV  out  1  memory operation valid.
- RW  out  1  RAM direction: 1 = read, 0 = write.
- Address  out  ADDR_W  RAM byte address.
- DataOut  out  8  byte to RAM DataIn.
- DataIn  in  8  byte from RAM DataOut.
- MOC  in  1  memory operation complete from RAM.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - Busy, Done, Error, Enable, MOV, RW, Address, DataOut, RData all 0; byte and timeout counters 0.
  - A reset asserted mid-transfer drops MOV and Enable at once. A partial store is not rolled back.
- Request latch:
  - In IDLE with Req=1, latch ReqRW, ReqSize, ReqSigned, ReqAddr and ReqWData.
  - If the request is legal, set Busy and go to SETUP. Req is ignored while Busy.
- Legality check:
  - Size 11, half with ReqAddr[0]=1, or word with ReqAddr[1:0]≠00 is illegal.
  - An illegal request goes to FINISH with Error; no RAM access occurs and RData is unchanged.
- Byte count: byte = 1, half = 2, word = 4. Byte k uses Address = ReqAddr+k, modulo 2^ADDR_W.
- Store byte order (big-endian):
  - word: k=0..3 ← ReqWData[31:24], [23:16], [15:8], [7:0].
  - half: ReqWData[15:8], then [7:0].
  - byte: ReqWData[7:0].
- Load assembly (same byte order into a shift register):
  - word fills [31:0].
  - half fills [15:0], then extends bit 15 (signed) or 0.
  - byte fills [7:0], then extends bit 7 or 0.
  - RData updates only on a successful load's Done cycle. It holds through stores and errors.
- States:
  - IDLE: Enable=0, MOV=0.
  - SETUP: one cycle. Enable=1, MOV=0; Address, RW and DataOut driven for byte k. Then → WAIT_MOC.
  - WAIT_MOC:
    - MOV=1, all other RAM outputs held stable.
    - On the first rising edge where MOC=1 (edge-detected against a registered MOC), capture DataIn if reading, then → RELEASE.
    - The timeout counter increments each cycle. On reaching TIMEOUT: drop MOV, set Error, → FINISH. No further bytes are issued.
  - RELEASE:
    - MOV=0, Enable=1; stay until MOC=0.
    - Then, if k < count−1: k++ → SETUP. Otherwise → FINISH.
  - FINISH: one cycle. Done=1, Error as flagged, Enable=0, Busy=0 on exit → IDLE.
- Handshake rules:
  - MOV never rises while MOC=1.
  - Address, RW and DataOut never change while MOV=1.
  - A level MOC held high across several cycles counts once (edge detect).
- Latency: with MOC high in the first WAIT_MOC cycle and low in the first RELEASE cycle, each byte takes 3 clocks. Done asserts 3·count+1 clocks after the accepting edge: byte = 4, half = 7, word = 13. An illegal request gives Done/Error 1 clock after acceptance.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010 → RAM bytes 0x10..0x13 = DE,AD,BE,EF; RData=0xDEADBEEF; Done 13 clocks after each Req; Error=0.
- Byte store 0x80 @0x005; signed byte load → RData=0xFFFFFF80; unsigned byte load → RData=0x00000080.
- Half store 0x8001 @0x020; signed half load → RData=0xFFFF8001; half load @0x021 → Done+Error after 1 clock, MOV never asserted, RData unchanged.
- MOC stuck low during a word load with TIMEOUT=16 → MOV drops after 16 WAIT_MOC clocks; Done+Error pulse; Busy clears; a following legal request completes normally.
- Reset asserted during byte 2 of a word store → MOV, Enable and Busy go 0 in the same timestep; state IDLE; bytes 0–1 written, bytes 2–3 untouched.
- MOC held high 3 cycles per byte, and Req pulsed while Busy → each byte is counted once; the extra Req is ignored; word completes with correct data.
